byte_lane_dpram: RTL and testbench



---
 rtl/byte_lane_dpram_pkg.sv | 16 +
 rtl/byte_lane_dpram_if.sv | 31 +++
 rtl/byte_lane_dpram_lane_bank.sv | 45 ++++
 rtl/byte_lane_dpram.sv | 88 ++++++++
 tb/tb_byte_lane_dpram.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/byte_lane_dpram_pkg.sv
// Shared types and constants for the byte-lane dual-port data memory.
// Lanes are always 8 bits wide; the lane count follows from the word width.
package byte_lane_dpram_pkg;

   localparam int LANE_BITS = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   function automatic int lanes_of(input int data_width);
      return data_width / LANE_BITS;
   endfunction

endpackage

// File: rtl/byte_lane_dpram_if.sv
// CPU, display and clear-control signals of the byte-lane data memory.
// The master drives addresses, data and strobes; the memory (slave) returns read data and busy.
interface byte_lane_dpram_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) ();
   import byte_lane_dpram_pkg::*;

   localparam int LANES = lanes_of(DATA_WIDTH);

   logic                  we;
   logic [LANES-1:0]      sel;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] d;
   logic [DATA_WIDTH-1:0] q;
   logic [ADDR_WIDTH-1:0] dispAddr;
   logic [DATA_WIDTH-1:0] dispColor;
   logic                  clr_req;
   logic                  busy;

   modport master (
      output we, sel, addr, d, dispAddr, clr_req,
      input  q, dispColor, busy
   );

   modport slave (
      input  we, sel, addr, d, dispAddr, clr_req,
      output q, dispColor, busy
   );

endinterface

// File: rtl/byte_lane_dpram_lane_bank.sv
// One 8-bit byte lane: port A is write/read with write-first read data,
// port B is read-only and returns the contents from before any same-cycle write.
module lane_bank
   import byte_lane_dpram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [LANE_BITS-1:0]  a_din,
   output logic [LANE_BITS-1:0]  a_dout,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic [LANE_BITS-1:0]  b_dout
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [LANE_BITS-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (a_we) begin
         mem[a_addr] <= a_din;
      end
   end

   // Write-first: a lane being written returns the new byte directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_dout <= '0;
      end else begin
         a_dout <= a_we ? a_din : mem[a_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_dout <= '0;
      end else begin
         b_dout <= mem[b_addr];
      end
   end

endmodule

// File: rtl/byte_lane_dpram.sv
// Dual-port data memory built from byte-lane banks, with a clear engine that
// owns the write path for DEPTH cycles after reset or on clr_req.
module byte_lane_dpram
   import byte_lane_dpram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic             rawclk,
   input  logic             rst_n,
   byte_lane_dpram_if.slave bus
);

   localparam int LANES = lanes_of(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] clr_ptr_reg;
   logic                  busy_reg;
   logic                  q_zero_reg;

   logic [LANES-1:0]      lane_we;
   logic [ADDR_WIDTH-1:0] port_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] q_raw;
   logic [DATA_WIDTH-1:0] disp_raw;

   always_ff @(posedge rawclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= CLEAR;
         clr_ptr_reg <= '0;
         busy_reg    <= 1'b1;
         q_zero_reg  <= 1'b1;
      end else begin
         // q of the cycle after a clearing cycle must read back as zero.
         q_zero_reg <= busy_reg;
         if (state_reg == CLEAR) begin
            if (clr_ptr_reg == LAST_ADDR) begin
               state_reg   <= IDLE;
               busy_reg    <= 1'b0;
               clr_ptr_reg <= '0;
            end else begin
               clr_ptr_reg <= clr_ptr_reg + ADDR_WIDTH'(1);
            end
         end else if (bus.clr_req) begin
            state_reg   <= CLEAR;
            busy_reg    <= 1'b1;
            clr_ptr_reg <= '0;
         end
      end
   end

   // Clear engine overrides the CPU on the shared write/read port.
   always_comb begin
      lane_we   = '0;
      port_addr = bus.addr;
      wr_data   = bus.d;
      if (state_reg == CLEAR) begin
         lane_we   = '1;
         port_addr = clr_ptr_reg;
         wr_data   = '0;
      end else if (bus.we) begin
         lane_we   = bus.sel;
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         lane_bank #(
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_bank (
            .clk    (rawclk),
            .rst_n  (rst_n),
            .a_we   (lane_we[gi]),
            .a_addr (port_addr),
            .a_din  (wr_data[gi*LANE_BITS +: LANE_BITS]),
            .a_dout (q_raw[gi*LANE_BITS +: LANE_BITS]),
            .b_addr (bus.dispAddr),
            .b_dout (disp_raw[gi*LANE_BITS +: LANE_BITS])
         );
      end
   endgenerate

   assign bus.q         = q_zero_reg ? '0 : q_raw;
   assign bus.dispColor = disp_raw;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_byte_lane_dpram.sv
// Bench for byte_lane_dpram: a 32-bit x 1024 instance against a word-level
// model, plus a 64-bit x 16 instance for wide-lane and short-clear checks.
module tb_byte_lane_dpram;
   import byte_lane_dpram_pkg::*;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;
   localparam int LN    = DW / 8;
   localparam int AW2   = 4;
   localparam int DW2   = 64;

   logic rawclk = 1'b0;
   logic rst_n  = 1'b0;
   logic rst2_n = 1'b0;

   always #5 rawclk = ~rawclk;

   byte_lane_dpram_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW))  bus  ();
   byte_lane_dpram_if #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW2)) bus2 ();

   byte_lane_dpram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .rawclk (rawclk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   byte_lane_dpram #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW2)) dut2 (
      .rawclk (rawclk),
      .rst_n  (rst2_n),
      .bus    (bus2)
   );

   int tests = 0;
   int fails = 0;

   // Word-level model: memory image, which words hold a defined value, and
   // how many clear cycles remain.
   logic [DW-1:0] ref_mem [DEPTH];
   logic          known   [DEPTH];
   int            clear_left;
   logic [DW-1:0] exp_q;
   logic [DW-1:0] exp_disp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge rawclk);
      #1;
   endtask

   task automatic cycle(input logic w, input logic [LN-1:0] s, input logic [AW-1:0] a,
                        input logic [DW-1:0] dd, input logic [AW-1:0] da, input logic c);
      logic          dk;
      logic [AW-1:0] ci;
      bus.we = w; bus.sel = s; bus.addr = a; bus.d = dd; bus.dispAddr = da; bus.clr_req = c;
      dk       = known[da];
      exp_disp = ref_mem[da];
      if (clear_left > 0) begin
         ci          = AW'(DEPTH - clear_left);
         ref_mem[ci] = '0;
         known[ci]   = 1'b1;
         clear_left--;
         exp_q = '0;
      end else begin
         if (w) begin
            for (int i = 0; i < LN; i++) begin
               if (s[i]) ref_mem[a][8*i +: 8] = dd[8*i +: 8];
            end
         end
         exp_q = ref_mem[a];
         if (c) clear_left = DEPTH;
      end
      tick();
      check("q", 64'(bus.q), 64'(exp_q));
      check("busy", 64'(bus.busy), 64'(clear_left > 0));
      if (dk) check("dispColor", 64'(bus.dispColor), 64'(exp_disp));
      if (w || c || !bus.busy)
         $display("[TB] we=%0b sel=%h addr=%0d d=%h disp=%0d clr=%0b -> q=%h dispColor=%h busy=%0b",
                  w, s, a, dd, da, c, bus.q, bus.dispColor, bus.busy);
      bus.we = 1'b0; bus.clr_req = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (bus.busy && n < 2000) begin
         cycle(1'b0, '0, '0, '0, AW'($urandom_range(0, DEPTH-1)), 1'b0);
         n++;
      end
      check(tag, 64'(n), 64'(DEPTH));
   endtask

   initial begin
      int n;
      bus.we = 0; bus.sel = '0; bus.addr = '0; bus.d = '0; bus.dispAddr = '0; bus.clr_req = 0;
      bus2.we = 0; bus2.sel = '0; bus2.addr = '0; bus2.d = '0; bus2.dispAddr = '0; bus2.clr_req = 0;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

      // Reset values
      tick(); tick();
      check("rst_q", 64'(bus.q), 64'h0);
      check("rst_disp", 64'(bus.dispColor), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h1);
      check("rst2_busy", 64'(bus2.busy), 64'h1);
      rst_n = 1'b1;
      clear_left = DEPTH;
      exp_q = '0;

      // Initial clear, then corner reads
      drain("init_clear_len");
      cycle(0, '0, AW'(0),    '0, AW'(0),    0);
      cycle(0, '0, AW'(511),  '0, AW'(511),  0);
      cycle(0, '0, AW'(1023), '0, AW'(1023), 0);
      check("rd1023_q", 64'(bus.q), 64'h0);
      cycle(0, '0, AW'(1023), '0, AW'(1023), 0);
      check("rd1023_disp", 64'(bus.dispColor), 64'h0);

      // Partial-lane merge
      cycle(1, 4'b1111, AW'(5), 32'hAABBCCDD, AW'(0), 0);
      cycle(1, 4'b0100, AW'(5), 32'h00110000, AW'(0), 0);
      cycle(0, '0, AW'(5), '0, AW'(5), 0);
      check("merge_q", 64'(bus.q), 64'hAA11CCDD);
      cycle(1, 4'b0000, AW'(5), 32'hFFFFFFFF, AW'(5), 0);
      check("sel0_noop", 64'(bus.q), 64'hAA11CCDD);

      // Same-word CPU write and display read
      cycle(1, 4'b1111, AW'(7), 32'h12345678, AW'(7), 0);
      check("collide_disp_old", 64'(bus.dispColor), 64'h0);
      check("collide_q_new", 64'(bus.q), 64'h12345678);
      cycle(0, '0, AW'(7), '0, AW'(7), 0);
      check("collide_disp_next", 64'(bus.dispColor), 64'h12345678);

      // Randomized traffic on a small address window
      for (int k = 0; k < 300; k++) begin
         cycle(1'($urandom_range(0, 1)), LN'($urandom_range(0, 15)), AW'($urandom_range(0, 31)),
               DW'($urandom), AW'($urandom_range(0, 31)), 1'b0);
      end

      // Clear on request with a dropped write and a repeated request
      cycle(1, 4'b1111, AW'(3),    32'hDEADBEEF, AW'(0), 0);
      cycle(1, 4'b1111, AW'(1000), 32'hCAFEF00D, AW'(0), 0);
      cycle(0, '0, AW'(0), '0, AW'(0), 1);
      n = 0;
      while (bus.busy && n < 2000) begin
         cycle(n == 2, 4'b1111, AW'(3), 32'h55555555, (n < 600) ? AW'(1000) : AW'(3), n == 500);
         n++;
      end
      check("req_clear_len", 64'(n), 64'(DEPTH));
      cycle(0, '0, AW'(3), '0, AW'(3), 0);
      check("dropped_write", 64'(bus.q), 64'h0);

      // Reset in the middle of a clear
      cycle(1, 4'b1111, AW'(1010), 32'h0BADC0DE, AW'(0), 0);
      cycle(0, '0, AW'(0), '0, AW'(0), 1);
      for (int k = 0; k < 300; k++) cycle(0, '0, AW'(0), '0, AW'(1010), 0);
      check("pre_rst_disp", 64'(bus.dispColor), 64'h0BADC0DE);
      rst_n = 1'b0;
      #1;
      check("midrst_q", 64'(bus.q), 64'h0);
      check("midrst_disp", 64'(bus.dispColor), 64'h0);
      check("midrst_busy", 64'(bus.busy), 64'h1);
      clear_left = DEPTH;
      exp_q = '0;
      tick();
      rst_n = 1'b1;
      drain("rst_clear_len");
      cycle(0, '0, AW'(1010), '0, AW'(1010), 0);
      cycle(0, '0, AW'(5), '0, AW'(5), 0);
      check("after_rst_clear", 64'(bus.q), 64'h0);

      // 64-bit x 16 instance
      check("rst2_q", 64'(bus2.q), 64'h0);
      rst2_n = 1'b1;
      n = 0;
      while (bus2.busy && n < 100) begin
         tick();
         n++;
      end
      check("w64_clear_len", 64'(n), 64'd16);
      bus2.we = 1; bus2.sel = 8'h81; bus2.addr = '0; bus2.d = 64'hFF112233445566EE; bus2.dispAddr = '0;
      tick();
      bus2.we = 0;
      $display("[TB] w64 write sel=81 addr=0 -> q=%h dispColor=%h", bus2.q, bus2.dispColor);
      check("w64_q_wr", 64'(bus2.q), 64'hFF000000000000EE);
      check("w64_disp_old", 64'(bus2.dispColor), 64'h0);
      tick();
      $display("[TB] w64 read addr=0 -> q=%h dispColor=%h", bus2.q, bus2.dispColor);
      check("w64_q_rd", 64'(bus2.q), 64'hFF000000000000EE);
      check("w64_disp", 64'(bus2.dispColor), 64'hFF000000000000EE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
